// File: rtl/rv_pkg.sv
// Shared types and decode helpers for the RV32M multiply/divide unit.
package rv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } muldiv_state_e;

  function automatic logic op_is_div(muldiv_op_e op);
    return op[2];
  endfunction

  function automatic logic rs1_is_signed(muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic rs2_is_signed(muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Divide by zero and signed overflow bypass the iterative datapath.
  function automatic logic op_is_special(muldiv_op_e op, logic [31:0] a, logic [31:0] b);
    return op_is_div(op) &&
           ((b == 32'h0) || (rs2_is_signed(op) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
  endfunction

endpackage

// File: rtl/rv_muldiv.sv
// Iterative RV32M execute unit: radix-2 shift-add multiply and restoring
// divide sharing one 64-bit accumulator and one final negate path.
module rv_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            write
);
  import rv_pkg::*;

  if (XLEN != 32) begin : g_xlen_check
    $error("rv_muldiv supports XLEN=32 only");
  end

  muldiv_state_e state_q, state_d;
  muldiv_op_e    op_q, op_d;
  logic [31:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic [63:0]   acc_q, acc_d;
  logic [4:0]    cnt_q, cnt_d, rd_q, rd_d;
  logic          pend_q, pend_d, busy_q, busy_d, done_q, done_d, write_q, write_d;

  // Operand magnitudes, 33 bits wide so -0x80000000 stays representable.
  logic        a_neg, b_neg;
  logic [32:0] a_mag, b_mag;
  assign a_neg = rs1_is_signed(op_q) & a_q[31];
  assign b_neg = rs2_is_signed(op_q) & b_q[31];
  assign a_mag = a_neg ? (33'd0 - {1'b1, a_q}) : {1'b0, a_q};
  assign b_mag = b_neg ? (33'd0 - {1'b1, b_q}) : {1'b0, b_q};

  // One radix-2 step of each algorithm on the shared accumulator.
  logic [32:0] mul_sum, div_trial, div_diff;
  logic [63:0] mul_next, div_next;
  assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? b_mag : 33'd0);
  assign mul_next  = {mul_sum, acc_q[31:1]};
  assign div_trial = acc_q[63:31];
  assign div_diff  = div_trial - b_mag;
  assign div_next  = div_diff[32] ? {div_trial[31:0], acc_q[30:0], 1'b0}
                                  : {div_diff[31:0],  acc_q[30:0], 1'b1};

  // Single sign-correction negate; source and sign depend on the op.
  logic        fix_neg;
  logic [63:0] fix_src, fix_val;
  logic [31:0] fix_res, special_res;
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    fix_neg = a_neg ^ b_neg;
    fix_src = acc_q;
    if (op_is_div(op_q)) begin
      if (op_q[1]) begin
        fix_neg = a_neg;
        fix_src = {32'd0, acc_q[63:32]};
      end else begin
        fix_src = {32'd0, acc_q[31:0]};
      end
    end
    fix_val = fix_neg ? (64'd0 - fix_src) : fix_src;
    fix_res = ((op_q == OP_MULH) || (op_q == OP_MULHSU) || (op_q == OP_MULHU)) ? fix_val[63:32]
                                                                               : fix_val[31:0];
    if (b_q == 32'd0) special_res = op_q[1] ? a_q : 32'hFFFF_FFFF;
    else              special_res = op_q[1] ? 32'd0 : 32'h8000_0000;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rd_d    = rd_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    pend_d  = pend_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    write_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          // Second IDLE cycle: load magnitudes or resolve a special case.
          pend_d = 1'b0;
          if (op_is_special(op_q, a_q, b_q)) begin
            res_d   = special_res;
            done_d  = 1'b1;
            write_d = (rd_q != 5'd0);
            busy_d  = 1'b0;
            state_d = DONE;
          end else begin
            acc_d   = {32'd0, a_mag[31:0]};
            cnt_d   = 5'd31;
            busy_d  = 1'b1;
            state_d = CALC;
          end
        end else if (start) begin
          op_d   = muldiv_op_e'(funct3);
          a_d    = rs1_data;
          b_d    = rs2_data;
          rd_d   = rd_in;
          pend_d = 1'b1;
          busy_d = !op_is_special(muldiv_op_e'(funct3), rs1_data, rs2_data);
        end
      end
      CALC: begin
        acc_d = op_is_div(op_q) ? div_next : mul_next;
        if (cnt_q == 5'd0) state_d = FIX;
        else               cnt_d   = cnt_q - 5'd1;
      end
      FIX: begin
        res_d   = fix_res;
        done_d  = 1'b1;
        write_d = (rd_q != 5'd0);
        busy_d  = 1'b0;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so all flops update from the same pre-edge values.
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_MUL;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      write_q <= write_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = res_q;
  assign rd_out = rd_q;
  assign write  = write_q;

endmodule

// File: tb/tb_rv_muldiv.sv
// Self-checking bench for rv_muldiv: directed corner cases plus randomized
// ops compared against a plain-arithmetic reference model.
module tb_rv_muldiv;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd_in;
  logic        busy, done, write;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int vectors = 0;
  int miscompares = 0;

  rv_muldiv dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .funct3   (funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd_in    (rd_in),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .rd_out   (rd_out),
    .write    (write)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model from the M-extension arithmetic rules.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    longint          sp;
    longint unsigned up;
    int              ia = $signed(a);
    int              ib = $signed(b);
    logic [31:0]     r;
    case (f)
      3'b000: begin up = ua * ub; r = up[31:0];  end
      3'b001: begin sp = sa * sb; r = sp[63:32]; end
      3'b010: begin sp = sa * longint'(ub); r = sp[63:32]; end
      3'b011: begin up = ua * ub; r = up[63:32]; end
      3'b100: r = (b == 0) ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(ia / ib);
      3'b101: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: r = (b == 0) ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(ia % ib);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic logic is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && (b == 0 || ((f == 3'b100 || f == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Issue one op, measure latency, check result/rd/write and the done pulse.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit noise);
    logic [31:0] exp = model(f, a, b);
    bit          special = is_special(f, a, b);
    int          lat = special ? 1 : 34;
    int          edges = 0;
    bit          seen = 0;
    @(negedge clk);
    start = 1'b1; funct3 = f; rs1_data = a; rs2_data = b; rd_in = rd;
    @(posedge clk); #1;
    start = 1'b0; rs1_data = $urandom; rs2_data = $urandom; rd_in = 5'($urandom);
    check("busy_after_accept", 32'(busy), 32'(!special));
    while (!seen && edges < 60) begin
      if (noise && edges >= 2 && edges < 25) begin
        start = 1'b1; funct3 = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom; rd_in = 5'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
      if (done) seen = 1;
    end
    start = 1'b0;
    check("latency", 32'(edges), 32'(lat));
    if (seen) begin
      check("result", result, exp);
      check("rd_out", 32'(rd_out), 32'(rd));
      check("write", 32'(write), 32'(rd != 0));
      check("busy_at_done", 32'(busy), 32'd0);
    end
    @(posedge clk); #1;
    check("done_pulse_end", 32'(done), 32'd0);
    check("write_pulse_end", 32'(write), 32'd0);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int pulses;
    reset = 1'b1; start = 1'b0; funct3 = '0; rs1_data = '0; rs2_data = '0; rd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_rd_out", 32'(rd_out), 32'd0);
    check("reset_write", 32'(write), 32'd0);
    @(negedge clk); reset = 1'b0;

    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 0);
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 0);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0);
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4, 0);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 0);
    run_op(3'b101, 32'd100, 32'd7, 5'd7, 0);
    run_op(3'b111, 32'd100, 32'd7, 5'd8, 0);
    run_op(3'b100, 32'd5, 32'd0, 5'd9, 0);
    run_op(3'b111, 32'd5, 32'd0, 5'd10, 0);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0);

    // Starts while busy must be ignored.
    run_op(3'b000, 32'd1234, 32'd5678, 5'd13, 1);

    // Reset in the middle of a calculation.
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; rs1_data = 32'd11; rs2_data = 32'd13; rd_in = 5'd14;
    @(posedge clk); #1; start = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    check("midreset_result", result, 32'd0);
    check("midreset_write", 32'(write), 32'd0);
    @(negedge clk); reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || write) pulses++;
    end
    check("no_pulse_after_reset", 32'(pulses), 32'd0);
    run_op(3'b011, 32'd3, 32'd5, 5'd15, 0);

    run_op(3'b000, 32'd2, 32'd3, 5'd0, 0);

    // Back-to-back: second op starts in the cycle right after DONE.
    run_op(3'b101, 32'd9, 32'd3, 5'd16, 0);
    run_op(3'b111, 32'd9, 32'd4, 5'd17, 0);

    for (int i = 0; i < 60; i++) begin
      run_op(3'($urandom), rand_operand(), rand_operand(), 5'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rv_muldiv.md
Name: rv_muldiv

Overview:
- Iterative RV32M multiply/divide execute unit.
- Consumes the two register-file read operands and produces a writeback word, destination index and write strobe aimed at the register-file write port.
- Handles all eight M-extension ops with one shared 64-bit accumulator.
- One radix-2 step per cycle; the decode/control FSM stalls on busy.

Parameters:
XLEN, 32, operand/result width; only 32 is supported; elaboration error otherwise.

Ports:
clk  input  1  rising-edge clock
reset  input  1  one clock; reset is synchronous and active-high
start  input  1  request; sampled only while busy=0
funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_data  input  XLEN  operand A (register-file read port 1)
rs2_data  input  XLEN  operand B (register-file read port 2)
rd_in  input  5  destination register index
busy  output  1  high from the cycle after start acceptance until done
done  output  1  one-cycle pulse; result and rd_out valid
result  output  XLEN  writeback data; holds its value until the next done
rd_out  output  5  latched rd_in
write  output  1  done && (rd_out != 0); drives the register-file write enable

Behaviour:
- Reset (synchronous, priority over everything):
  - State goes to IDLE.
  - busy=0, done=0, write=0, result=0, rd_out=0, counter=0.
  - An in-flight op is discarded and no write pulse is produced.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 latches funct3, rs1_data, rs2_data and rd_in.
  - Special case (divide op with divisor==0, or DIV/REM with 0x80000000 / 0xFFFFFFFF) goes to DONE.
  - Otherwise goes to CALC with counter=31. busy is asserted from the next cycle.
- CALC, one step per cycle for 32 cycles:
  - Multiply: shift-add on operand magnitudes.
  - Divide: restoring shift-subtract on magnitudes.
  - Counter decrements; counter==0 goes to FIX.
- FIX:
  - Applies sign correction (two's-complement negate) and selects the result half.
  - MUL takes product[31:0]; MULH/MULHSU/MULHU take product[63:32].
  - DIV/DIVU take the quotient; REM/REMU take the remainder.
  - Goes to DONE.
- DONE: done=1, write per rd_out, busy=0 in this cycle; goes to IDLE.
- Latency, counted as rising edges after the start-sampling edge until done is observed high:
  - Normal ops: 34 edges (1 load + 32 CALC + 1 FIX).
  - Special cases: 1 edge.
  - Back-to-back: a new start may be accepted in the cycle after DONE, i.e. in IDLE.
- start while busy=1, or in the DONE cycle: ignored; inputs are not re-latched. Operand inputs may change freely after acceptance.
- Signedness:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - MUL: lower half, sign-agnostic.
  - Quotient is negative iff the operand signs differ; remainder takes the dividend's sign.
- Divide by zero: quotient = 0xFFFFFFFF (DIV and DIVU); remainder = dividend.
- Signed overflow (0x80000000 / -1): quotient = 0x80000000, remainder = 0.
- Magnitude of 0x80000000 is computed in 33 bits internally, so there is no overflow.
- funct3 is fully decoded; there are no illegal codes.

Decomposition:
- Shared package rv_pkg holds:
  - XLEN localparam.
  - muldiv_op_e enum for the funct3 encodings above.
  - muldiv_state_e enum {IDLE, CALC, FIX, DONE}.
- No sub-module. The shared accumulator and single negate path stay in one module, roughly 200 lines.

Test Plan:
- Signed MUL: MUL rs1=7, rs2=0xFFFFFFFD (-3), rd=5 → done at edge 34, result=0xFFFFFFEB, rd_out=5, write high exactly one cycle, busy low the same cycle.
- High-half multiplies:
  - MULH 0x80000000*0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFF.
- Divide/remainder:
  - DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD.
  - REM -7 / 2 → 0xFFFFFFFF.
  - DIVU 100/7 → 0x0000000E.
  - REMU 100/7 → 0x00000002.
- Special cases, each with done at edge 1 and no busy cycle:
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 0x00000005.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same → 0x00000000.
- Busy and reset:
  - Second start with different operands while busy → ignored; first result is unchanged.
  - reset=1 at CALC cycle 10 → next edge busy=0, done=0, result=0, no write pulse.
  - Following MULHU 3*5 → 0x00000000 with rd_out correct.
- rd=0: MUL 2*3, rd=0 → done pulses with result=6, write stays 0.
- Back-to-back: DIVU 9/3 then REMU 9/4, started in the cycle after DONE → results 3 then 1, each at edge 34.
